// File: rtl/gearbox_downsizing_nx_if.sv
// Stream bundle for the width down-converter: wide input side, narrow output side
// and the occupancy flag. The DUT takes the slave view, the upstream/downstream the master view.
interface gearbox_downsizing_nx_if #(
    parameter int BYTES_OUT = 5,
    parameter int RATIO     = 2
);
    localparam int NB = BYTES_OUT * 8;
    localparam int PW = $clog2(RATIO) + 1;

    logic [RATIO*NB-1:0] in_tdata;
    logic                in_tvalid;
    logic                in_tready;
    logic [PW-1:0]       in_tparts;
    logic                in_tlast;
    logic [NB-1:0]       out_tdata;
    logic                out_tvalid;
    logic                out_tready;
    logic                out_tlast;
    logic                busy;

    modport master (
        output in_tdata, in_tvalid, in_tparts, in_tlast, out_tready,
        input  in_tready, out_tdata, out_tvalid, out_tlast, busy
    );

    modport slave (
        input  in_tdata, in_tvalid, in_tparts, in_tlast, out_tready,
        output in_tready, out_tdata, out_tvalid, out_tlast, busy
    );
endinterface

// File: rtl/gearbox_downsizing_nx.sv
// AXI-Stream width down-converter: one wide beat of up to RATIO parts leaves as that many
// narrow beats, part 0 first; back-to-back reload on the last part keeps throughput at one beat per cycle.
module gearbox_downsizing_nx #(
    parameter int BYTES_OUT = 5,
    parameter int RATIO     = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    gearbox_downsizing_nx_if.slave  bus
);
    localparam int NB = BYTES_OUT * 8;
    localparam int IW = $clog2(RATIO);
    localparam int PW = IW + 1;

    logic [RATIO*NB-1:0] hold_data_reg;
    logic [PW-1:0]       hold_parts_reg;
    logic [IW-1:0]       idx_reg;
    logic                hold_last_reg;
    logic                busy_reg;

    logic                is_last;
    logic                ready_int;
    logic                in_fire;
    logic                out_fire;
    logic [PW-1:0]       parts_norm;
    logic [NB-1:0]       part_w [RATIO];

    // A part count of zero or above RATIO means a full beat.
    always_comb begin
        parts_norm = bus.in_tparts;
        if (bus.in_tparts == '0 || bus.in_tparts > PW'(RATIO)) begin
            parts_norm = PW'(RATIO);
        end
    end

    assign is_last   = ({1'b0, idx_reg} == hold_parts_reg - PW'(1));
    // Ready only looks at state and out_tready, so no path from in_tvalid to in_tready.
    assign ready_int = !busy_reg || (bus.out_tready && is_last);
    assign in_fire   = bus.in_tvalid && ready_int;
    assign out_fire  = busy_reg && bus.out_tready;

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_part
        assign part_w[gi] = hold_data_reg[gi*NB +: NB];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_data_reg  <= '0;
            hold_parts_reg <= PW'(1);
            idx_reg        <= '0;
            hold_last_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else if (in_fire) begin
            // Covers both the empty case and the zero-bubble reload on the last part.
            hold_data_reg  <= bus.in_tdata;
            hold_parts_reg <= parts_norm;
            idx_reg        <= '0;
            hold_last_reg  <= bus.in_tlast;
            busy_reg       <= 1'b1;
        end else if (out_fire) begin
            if (is_last) begin
                busy_reg <= 1'b0;
            end else begin
                idx_reg  <= idx_reg + IW'(1);
            end
        end
    end

    assign bus.in_tready  = ready_int;
    assign bus.out_tvalid = busy_reg;
    assign bus.busy       = busy_reg;
    assign bus.out_tdata  = part_w[idx_reg];
    assign bus.out_tlast  = hold_last_reg && is_last;

endmodule

// File: tb/tb_gearbox_downsizing_nx.sv
// Bench for gearbox_downsizing_nx: a RATIO=2 and a RATIO=4 instance share clock and reset;
// expected narrow beats are queued at drive time and compared as the DUTs emit them.
module tb_gearbox_downsizing_nx;
    localparam int NB = 40;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    gearbox_downsizing_nx_if #(.BYTES_OUT(5), .RATIO(2)) if2 ();
    gearbox_downsizing_nx_if #(.BYTES_OUT(5), .RATIO(4)) if4 ();

    gearbox_downsizing_nx #(.BYTES_OUT(5), .RATIO(2)) dut2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (if2.slave)
    );

    gearbox_downsizing_nx #(.BYTES_OUT(5), .RATIO(4)) dut4 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (if4.slave)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cnt2 = 0;
    int cnt4 = 0;
    bit rand_mode = 1'b0;
    logic [NB:0] q2[$];
    logic [NB:0] q4[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int norm(input int p, input int r);
        return (p == 0 || p > r) ? r : p;
    endfunction

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Output monitors: scoreboard pop on each transfer plus stall-stability check.
    initial begin
        bit stall;
        logic [NB:0] held;
        logic [NB:0] e;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold2_valid", if2.out_tvalid, 1);
                    check("hold2_beat", {if2.out_tlast, if2.out_tdata}, held);
                end
                if (if2.out_tvalid && if2.out_tready) begin
                    if (q2.size() == 0) begin
                        check("sb2_extra_beat", 1, 0);
                    end else begin
                        e = q2.pop_front();
                        check("out2_data", if2.out_tdata, e[NB-1:0]);
                        check("out2_last", if2.out_tlast, e[NB]);
                    end
                    cnt2++;
                end
                stall = if2.out_tvalid && !if2.out_tready;
                held = {if2.out_tlast, if2.out_tdata};
            end
        end
    end

    initial begin
        bit stall;
        logic [NB:0] held;
        logic [NB:0] e;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold4_valid", if4.out_tvalid, 1);
                    check("hold4_beat", {if4.out_tlast, if4.out_tdata}, held);
                end
                if (if4.out_tvalid && if4.out_tready) begin
                    if (q4.size() == 0) begin
                        check("sb4_extra_beat", 1, 0);
                    end else begin
                        e = q4.pop_front();
                        check("out4_data", if4.out_tdata, e[NB-1:0]);
                        check("out4_last", if4.out_tlast, e[NB]);
                    end
                    cnt4++;
                end
                stall = if4.out_tvalid && !if4.out_tready;
                held = {if4.out_tlast, if4.out_tdata};
            end
        end
    end

    // Random back-pressure: low runs 1..6 cycles, high runs 0..6 cycles.
    initial begin
        int run;
        run = 0;
        forever begin
            @(posedge aclk);
            #3;
            if (rand_mode) begin
                if (run > 0) begin
                    run--;
                end else if (if2.out_tready) begin
                    if2.out_tready = 1'b0;
                    if4.out_tready = 1'b0;
                    run = $urandom_range(1, 6) - 1;
                end else begin
                    run = $urandom_range(0, 6);
                    if (run > 0) begin
                        if2.out_tready = 1'b1;
                        if4.out_tready = 1'b1;
                        run--;
                    end else begin
                        run = $urandom_range(1, 6) - 1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send2(input logic [79:0] d, input int p, input bit l);
        int n;
        bit ok;
        n = norm(p, 2);
        if2.in_tdata  = d;
        if2.in_tparts = 2'(p);
        if2.in_tlast  = l;
        if2.in_tvalid = 1'b1;
        for (int i = 0; i < n; i++) q2.push_back({l && (i == n - 1), d[i*NB +: NB]});
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (if2.in_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send2_timeout", 0, 1);
        @(posedge aclk);
        #1;
        if2.in_tvalid = 1'b0;
        $display("in2 data=%h parts=%0d last=%0b", d, p, l);
    endtask

    task automatic send4(input logic [159:0] d, input int p, input bit l);
        int n;
        bit ok;
        n = norm(p, 4);
        if4.in_tdata  = d;
        if4.in_tparts = 3'(p);
        if4.in_tlast  = l;
        if4.in_tvalid = 1'b1;
        for (int i = 0; i < n; i++) q4.push_back({l && (i == n - 1), d[i*NB +: NB]});
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (if4.in_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send4_timeout", 0, 1);
        @(posedge aclk);
        #1;
        if4.in_tvalid = 1'b0;
        $display("in4 data=%h parts=%0d last=%0b", d, p, l);
    endtask

    task automatic drain2(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(posedge aclk);
            #2;
            if (q2.size() == 0) break;
        end
        if (q2.size() != 0) check("drain2_timeout", q2.size(), 0);
    endtask

    task automatic drain4(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(posedge aclk);
            #2;
            if (q4.size() == 0) break;
        end
        if (q4.size() != 0) check("drain4_timeout", q4.size(), 0);
    endtask

    initial begin
        int base;
        int c0;
        int sum;
        int p;
        bit l;
        logic [79:0] d2;
        logic [159:0] d4;

        if2.in_tdata = '0; if2.in_tvalid = 1'b0; if2.in_tparts = '0; if2.in_tlast = 1'b0;
        if2.out_tready = 1'b1;
        if4.in_tdata = '0; if4.in_tvalid = 1'b0; if4.in_tparts = '0; if4.in_tlast = 1'b0;
        if4.out_tready = 1'b1;

        #2;
        check("rst_valid", if2.out_tvalid, 0);
        check("rst_busy", if2.busy, 0);
        check("rst_data", if2.out_tdata, 0);
        check("rst_last", if2.out_tlast, 0);
        check("rst_ready", if2.in_tready, 1);
        check("rst_valid4", if4.out_tvalid, 0);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: single full beat, part 0 from the low bytes first
        send2("ABCDEFGHIJ", 0, 1'b0);
        check("t1_valid", if2.out_tvalid, 1);
        check("t1_part0", if2.out_tdata, "FGHIJ");
        check("t1_ready_part0", if2.in_tready, 0);
        @(posedge aclk);
        #1;
        check("t1_part1", if2.out_tdata, "ABCDE");
        check("t1_ready_part1", if2.in_tready, 1);
        check("t1_nolast", if2.out_tlast, 0);
        @(posedge aclk);
        #1;
        check("t1_idle", if2.out_tvalid, 0);
        drain2(20);

        // 2: back-to-back full beats at one output per cycle
        @(posedge aclk);
        #1;
        c0 = cyc;
        base = cnt2;
        for (int k = 0; k < 500; k++) begin
            d2 = {16'($urandom), $urandom, $urandom};
            send2(d2, 0, 1'(k % 7 == 6));
        end
        drain2(50);
        check("t2_count", cnt2 - base, 1000);
        check("t2_cycles", cyc - c0, 1001);

        // 3: back-pressure on part 0
        if2.out_tready = 1'b0;
        send2("KLMONPQRST", 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("t3_valid", if2.out_tvalid, 1);
            check("t3_data", if2.out_tdata, "PQRST");
            check("t3_ready", if2.in_tready, 0);
            @(posedge aclk);
            #1;
        end
        if2.out_tready = 1'b1;
        drain2(20);

        // 4/5: RATIO=4 partial words
        base = cnt4;
        d4 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send4(d4, 1, 1'b1);
        drain4(20);
        check("t4_count", cnt4 - base, 1);
        base = cnt4;
        d4 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        send4(d4, 3, 1'b1);
        drain4(20);
        check("t5_count", cnt4 - base, 3);

        // 6: async reset drops a pending beat
        base = cnt2;
        if2.out_tready = 1'b0;
        send2({40'h0, "ABCDE"}, 1, 1'b1);
        #3;
        aresetn = 1'b0;
        #1;
        check("t6_valid", if2.out_tvalid, 0);
        check("t6_busy", if2.busy, 0);
        check("t6_data", if2.out_tdata, 0);
        check("t6_ready", if2.in_tready, 1);
        q2.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("t6_ready_after", if2.in_tready, 1);
        if2.out_tready = 1'b1;
        send2("UVWXYZ0123", 0, 1'b0);
        drain2(20);
        check("t6_count", cnt2 - base, 2);

        // 7: random pauses and back-pressure, RATIO=2 then RATIO=4
        rand_mode = 1'b1;
        base = cnt2;
        sum = 0;
        for (int k = 0; k < 500; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge aclk);
                #1;
            end
            p = $urandom_range(0, 3);
            l = 1'($urandom_range(0, 1));
            sum += norm(p, 2);
            d2 = {16'($urandom), $urandom, $urandom};
            send2(d2, p, l);
        end
        rand_mode = 1'b0;
        if2.out_tready = 1'b1;
        if4.out_tready = 1'b1;
        drain2(200);
        check("t7_count2", cnt2 - base, sum);

        rand_mode = 1'b1;
        base = cnt4;
        sum = 0;
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge aclk);
                #1;
            end
            p = $urandom_range(0, 7);
            l = 1'($urandom_range(0, 1));
            sum += norm(p, 4);
            d4 = {$urandom, $urandom, $urandom, $urandom, $urandom};
            send4(d4, p, l);
        end
        rand_mode = 1'b0;
        if2.out_tready = 1'b1;
        if4.out_tready = 1'b1;
        drain4(200);
        check("t7_count4", cnt4 - base, sum);

        repeat (3) @(posedge aclk);
        #1;
        check("end_idle2", if2.out_tvalid, 0);
        check("end_idle4", if4.out_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
